// File: rtl/uart_prog_loader.sv
// Purpose: receive 8N1 UART bytes, assemble 32-bit words MSB first, write them to instruction memory, and hold the CPU while loading.
// Latency: rx pin fall to RX_START is 3 clk; stop-bit sample to byte_valid is 1 clk; 4th-byte byte_valid to im_we is 1 clk.
// Backpressure: none; the instruction memory must accept every im_we strobe, and strobes are at least 4 byte times apart.
module uart_prog_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 8,
    parameter int WORD_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [WORD_W-1:0] im_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {L_HDR, L_CNT, L_DATA} ld_state_t;

    logic             rx_meta, rx_s, rx_prev;
    rx_state_t        rx_state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       rx_byte;
    logic             byte_valid, frame_err;

    ld_state_t        ld_state;
    logic [1:0]       byte_idx;
    logic [23:0]      shift;
    logic [8:0]       n_words;
    logic [8:0]       w_cnt;

    // Two-flop synchronizer plus one history flop for falling-edge detection; all idle high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    // Byte receiver: start bit checked at half a bit, then data and stop sampled every full bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state   <= RX_IDLE;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        rx_state <= RX_START;
                        clk_cnt  <= '0;
                        bit_cnt  <= '0;
                    end
                end
                RX_START: begin
                    if (clk_cnt == HALF_M1) begin
                        clk_cnt  <= '0;
                        // A line that is high again at mid-start-bit was only a glitch.
                        rx_state <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (clk_cnt == FULL_M1) begin
                        clk_cnt <= '0;
                        rx_byte <= {rx_s, rx_byte[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_state <= RX_STOP;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_ONE;
                    end
                end
                RX_STOP: begin
                    if (clk_cnt == FULL_M1) begin
                        clk_cnt  <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_s) begin
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_ONE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Loader: header 0xA5, word count (0 = 256), then words MSB first into instruction memory.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_state  <= L_HDR;
            byte_idx  <= '0;
            shift     <= '0;
            n_words   <= '0;
            w_cnt     <= '0;
            im_we     <= 1'b0;
            im_addr   <= '0;
            im_wdata  <= '0;
            cpu_hold  <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            im_we     <= 1'b0;
            load_done <= 1'b0;
            // Address advances after each write; the CPU is released one cycle after the last write.
            if (im_we) begin
                im_addr <= im_addr + ADDR_W'(1);
            end
            if (load_done) begin
                cpu_hold <= 1'b0;
            end
            case (ld_state)
                L_HDR: begin
                    if (byte_valid && rx_byte == 8'hA5) begin
                        cpu_hold <= 1'b1;
                        load_err <= 1'b0;
                        im_addr  <= '0;
                        byte_idx <= '0;
                        w_cnt    <= '0;
                        ld_state <= L_CNT;
                    end
                end
                L_CNT: begin
                    if (frame_err) begin
                        load_err <= 1'b1;
                        ld_state <= L_HDR;
                    end else if (byte_valid) begin
                        n_words  <= (rx_byte == 8'h00) ? 9'd256 : {1'b0, rx_byte};
                        ld_state <= L_DATA;
                    end
                end
                L_DATA: begin
                    if (frame_err) begin
                        // CPU stays held: only a complete, clean load releases it.
                        load_err <= 1'b1;
                        ld_state <= L_HDR;
                    end else if (byte_valid) begin
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            im_we    <= 1'b1;
                            im_wdata <= {shift, rx_byte};
                            w_cnt    <= w_cnt + 9'd1;
                            if (w_cnt + 9'd1 == n_words) begin
                                load_done <= 1'b1;
                                ld_state  <= L_HDR;
                            end
                        end else begin
                            shift <= {shift[15:0], rx_byte};
                        end
                    end
                end
                default: ld_state <= L_HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: byte-level reference model of the load protocol,
// a per-cycle write checker, directed scenarios with literal expectations, and a random phase.
module tb_uart_prog_loader;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic        im_we;
    logic [7:0]  im_addr;
    logic [31:0] im_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(8), .WORD_W(32)) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state, advanced once per complete UART frame.
    int           m_phase;   // 0 waiting for header, 1 expecting count, 2 collecting words
    int           m_n, m_done, m_nb, m_addr;
    logic [31:0]  m_word;
    bit           m_hold, m_err;
    logic [40:0]  exp_q[$];  // {last, addr, data}
    logic [39:0]  wlog[$];   // observed {addr, data}
    int           done_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_phase = 0; m_hold = 0; m_err = 0; m_addr = 0; m_nb = 0; m_done = 0; m_n = 0;
        m_word = '0;
        exp_q.delete();
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        case (m_phase)
            0: if (b == 8'hA5) begin
                m_hold = 1; m_err = 0; m_addr = 0; m_nb = 0; m_done = 0; m_phase = 1;
            end
            1: begin
                m_n = (b == 8'h00) ? 256 : int'(b);
                m_phase = 2;
            end
            default: begin
                m_word = {m_word[23:0], b};
                m_nb++;
                if (m_nb == 4) begin
                    m_nb = 0;
                    m_done++;
                    exp_q.push_back({(m_done == m_n), 8'(m_addr), m_word});
                    m_addr = (m_addr + 1) % 256;
                    if (m_done == m_n) begin
                        m_hold = 0;
                        m_phase = 0;
                    end
                end
            end
        endcase
    endfunction

    function automatic void model_ferr();
        if (m_phase != 0) begin
            m_err = 1;
            m_phase = 0;
        end
    endfunction

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_cpu_hold"}, cpu_hold, m_hold);
        chk({tag, "_load_err"}, load_err, m_err);
        chk({tag, "_im_addr"}, im_addr, 8'(m_addr));
    endtask

    // One 8N1 frame; a bad stop bit is followed by one idle bit time. Gaps of 8+ cycles allow a state check.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int gap);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_ok);
        if (!stop_ok) send_bit(1'b1);
        rx = 1'b1;
        if (stop_ok) model_byte(b);
        else model_ferr();
        if (gap >= 8) begin
            repeat (8) @(negedge clk);
            check_state("frame");
            repeat (gap - 8) @(negedge clk);
        end else begin
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 3; k >= 0; k--) send_frame(w[8*k +: 8], 1'b1, gap);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_im_we"}, im_we, 0);
        chk({tag, "_im_addr"}, im_addr, 0);
        chk({tag, "_im_wdata"}, im_wdata, 0);
        chk({tag, "_cpu_hold"}, cpu_hold, 0);
        chk({tag, "_load_done"}, load_done, 0);
        chk({tag, "_load_err"}, load_err, 0);
    endtask

    // Per-cycle write checker: every strobe must match the model's next expected write.
    initial begin
        bit prev_we;
        logic [40:0] e;
        prev_we = 0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                chk("strobe_rules", {prev_we & im_we, load_done & ~im_we}, 0);
                if (im_we) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", im_addr, im_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("write", {load_done, im_addr, im_wdata}, e);
                        chk("hold_during_write", cpu_hold, 1);
                    end
                    wlog.push_back({im_addr, im_wdata});
                    if (load_done) done_cnt++;
                end
                prev_we = im_we;
            end else begin
                prev_we = 0;
            end
        end
    end

    // Safety net against a stuck run.
    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exceeded, expected end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        int nj, nw;
        rx = 1'b1;
        rst = 1'b1;
        done_cnt = 0;
        model_reset();
        #1 rst = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Nominal two-word load.
        wlog.delete(); done_cnt = 0;
        send_frame(8'hA5, 1'b1, 10);
        send_frame(8'h02, 1'b1, 10);
        send_word(32'h20010005, 10);
        send_word(32'h20020003, 10);
        repeat (10) @(negedge clk);
        chk("nom_nwrites", wlog.size(), 2);
        chk("nom_w0", wlog[0], {8'h00, 32'h20010005});
        chk("nom_w1", wlog[1], {8'h01, 32'h20020003});
        chk("nom_done", done_cnt, 1);
        chk("nom_hold", cpu_hold, 0);
        chk("nom_err", load_err, 0);

        // Header filtering.
        wlog.delete();
        send_frame(8'h00, 1'b1, 10);
        send_frame(8'hFF, 1'b1, 10);
        send_frame(8'h5A, 1'b1, 10);
        chk("hdr_hold_before", cpu_hold, 0);
        send_frame(8'hA5, 1'b1, 10);
        chk("hdr_hold_after", cpu_hold, 1);
        send_frame(8'h01, 1'b1, 10);
        send_word(32'hDEADBEEF, 10);
        repeat (10) @(negedge clk);
        chk("hdr_nwrites", wlog.size(), 1);
        chk("hdr_w0", wlog[0], {8'h00, 32'hDEADBEEF});

        // Framing error in the 3rd byte of the first word.
        wlog.delete();
        send_frame(8'hA5, 1'b1, 10);
        send_frame(8'h02, 1'b1, 10);
        send_frame(8'h20, 1'b1, 10);
        send_frame(8'h01, 1'b1, 10);
        send_frame(8'h00, 1'b0, 10);
        send_frame(8'h05, 1'b1, 10);
        repeat (10) @(negedge clk);
        chk("ferr_nwrites", wlog.size(), 0);
        chk("ferr_err", load_err, 1);
        chk("ferr_hold", cpu_hold, 1);
        send_frame(8'hA5, 1'b1, 10);
        chk("ferr_err_cleared", load_err, 0);
        send_frame(8'h01, 1'b1, 10);
        send_word(32'h00000008, 10);
        repeat (10) @(negedge clk);
        chk("ferr_recover_w0", wlog[0], {8'h00, 32'h00000008});
        chk("ferr_recover_hold", cpu_hold, 0);

        // One-cycle glitches: while idle in header wait, and between bytes mid-load.
        wlog.delete();
        @(negedge clk) rx = 1'b0;
        @(negedge clk) rx = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        check_state("glitch_idle");
        send_frame(8'hA5, 1'b1, 10);
        send_frame(8'h01, 1'b1, 10);
        send_frame(8'h00, 1'b1, 10);
        send_frame(8'h00, 1'b1, 10);
        @(negedge clk) rx = 1'b0;
        @(negedge clk) rx = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        check_state("glitch_load");
        send_frame(8'h00, 1'b1, 10);
        send_frame(8'h07, 1'b1, 10);
        repeat (10) @(negedge clk);
        chk("glitch_nwrites", wlog.size(), 1);
        chk("glitch_w0", wlog[0], {8'h00, 32'h00000007});

        // N=0 means 256 words; frames back to back, data includes 0xA5 bytes.
        wlog.delete(); done_cnt = 0;
        send_frame(8'hA5, 1'b1, 0);
        send_frame(8'h00, 1'b1, 0);
        for (int i = 0; i < 256; i++) begin
            send_word({8'(i), ~8'(i), 8'hA5, 8'(i) ^ 8'h3C}, 0);
        end
        repeat (12) @(negedge clk);
        chk("wrap_nwrites", wlog.size(), 256);
        chk("wrap_last", wlog[255], {8'hFF, 8'hFF, 8'h00, 8'hA5, 8'hC3});
        chk("wrap_done", done_cnt, 1);
        chk("wrap_addr", im_addr, 0);
        chk("wrap_hold", cpu_hold, 0);

        // Reset after the 2nd byte of word 1.
        wlog.delete();
        send_frame(8'hA5, 1'b1, 10);
        send_frame(8'h02, 1'b1, 10);
        send_frame(8'h11, 1'b1, 10);
        send_frame(8'h22, 1'b1, 10);
        chk("rst_hold_before", cpu_hold, 1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check_reset_outputs("midload_reset");
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_nwrites", wlog.size(), 0);
        send_frame(8'hA5, 1'b1, 10);
        send_frame(8'h01, 1'b1, 10);
        send_word(32'hCAFEBABE, 10);
        repeat (10) @(negedge clk);
        chk("rst_fresh_w0", wlog[0], {8'h00, 32'hCAFEBABE});

        // Random loads with junk bytes, random gaps and occasional framing errors.
        for (int it = 0; it < 12; it++) begin
            nj = $urandom_range(0, 2);
            for (int j = 0; j < nj; j++)
                send_frame(8'($urandom), $urandom_range(0, 7) != 0, $urandom_range(0, 12));
            send_frame(8'hA5, 1'b1, $urandom_range(0, 12));
            nw = $urandom_range(1, 3);
            send_frame(8'(nw), 1'b1, $urandom_range(0, 12));
            for (int j = 0; j < nw * 4; j++)
                send_frame(8'($urandom), $urandom_range(0, 15) != 0, $urandom_range(0, 12));
        end
        repeat (20) @(negedge clk);
        chk("exp_q_drained", exp_q.size(), 0);
        check_state("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
